// File: rtl/puf_challenge_issuer_if.sv
`default_nettype none
// puf_challenge_issuer_if: host, PUF-array and key-handshake signals of the challenge issuer.
// slave is the issuer's view; master is the host/array side driving start, seed, resp_bit and key_ready.
interface puf_challenge_issuer_if #(
    parameter int KEY_W = 16
);
    logic             start;
    logic [7:0]       seed;
    logic [4:0]       chal_a;
    logic [4:0]       chal_b;
    logic             osc_en;
    logic             cnt_clr;
    logic             resp_bit;
    logic             busy;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             key_ready;

    modport slave (
        input  start, seed, resp_bit, key_ready,
        output chal_a, chal_b, osc_en, cnt_clr, busy, key, key_valid
    );

    modport master (
        output start, seed, resp_bit, key_ready,
        input  chal_a, chal_b, osc_en, cnt_clr, busy, key, key_valid
    );
endinterface
`default_nettype wire

// File: rtl/puf_challenge_issuer.sv
`default_nettype none
// puf_challenge_issuer: LFSR-driven RO-PUF challenge sequencer assembling KEY_W response bits into a key.
// Optional PUF_MAJORITY_EN: three measurements per challenge with a 2-of-3 vote per key bit.
module puf_challenge_issuer #(
    parameter int KEY_W  = 16,
    parameter int WINDOW = 1024,
    parameter int SETTLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    puf_challenge_issuer_if.slave  bus_if
);
    localparam int CW = $clog2(WINDOW + SETTLE + 1);
    localparam int BW = $clog2(KEY_W);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_MEASURE = 3'd2,
        S_SETTLE  = 3'd3,
        S_SAMPLE  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]       lfsr_q, lfsr_d;
    logic [4:0]       chal_a_q, chal_b_q;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             chal_load;
    logic             last_round;
    logic             key_bit;
    logic [9:0]       chal_next;

    // Bank B is nudged off bank A so an oscillator is never compared with itself.
    function automatic logic [9:0] chal_pair(input logic [9:0] l);
        logic [4:0] b;
        b = l[9:5];
        if (b == l[4:0]) b = b ^ 5'h01;
        return {b, l[4:0]};
    endfunction

    assign chal_next = chal_pair(lfsr_d);

`ifdef PUF_MAJORITY_EN
    logic [1:0] round_q, round_d;
    logic [1:0] votes_q, votes_d;
    logic [1:0] votes_sum;

    assign votes_sum  = votes_q + {1'b0, bus_if.resp_bit};
    assign last_round = (round_q == 2'd2);
    assign key_bit    = (votes_sum >= 2'd2);

    always_comb begin
        round_d = round_q;
        votes_d = votes_q;
        if (state_q == S_IDLE && bus_if.start) begin
            round_d = 2'd0;
            votes_d = 2'd0;
        end else if (state_q == S_SAMPLE) begin
            if (last_round) begin
                round_d = 2'd0;
                votes_d = 2'd0;
            end else begin
                round_d = round_q + 2'd1;
                votes_d = votes_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q <= 2'd0;
            votes_q <= 2'd0;
        end else begin
            round_q <= round_d;
            votes_q <= votes_d;
        end
    end
`else
    assign last_round = 1'b1;
    assign key_bit    = bus_if.resp_bit;
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_cnt_d   = bit_cnt_q;
        lfsr_d      = lfsr_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        chal_load   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    state_d   = S_CLEAR;
                    bit_cnt_d = '0;
                    key_d     = '0;
                    lfsr_d    = {bus_if.seed, 2'b01};
                    chal_load = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d = S_MEASURE;
                cyc_d   = CW'(WINDOW - 1);
            end
            S_MEASURE: begin
                if (cyc_q == '0) begin
                    state_d = S_SETTLE;
                    cyc_d   = CW'(SETTLE - 1);
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            S_SETTLE: begin
                if (cyc_q == '0) state_d = S_SAMPLE;
                else             cyc_d   = cyc_q - 1'b1;
            end
            S_SAMPLE: begin
                state_d = S_CLEAR;
                if (last_round) begin
                    key_d = {key_q[KEY_W-2:0], key_bit};
                    if (bit_cnt_q == BW'(KEY_W - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
                        chal_load = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // key_valid is registered, so it rises on the second DONE cycle.
                key_valid_d = 1'b1;
                if (key_valid_q && bus_if.key_ready) begin
                    state_d     = S_IDLE;
                    key_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            bit_cnt_q   <= '0;
            lfsr_q      <= 10'h001;
            chal_a_q    <= 5'h00;
            chal_b_q    <= 5'h00;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_cnt_q   <= bit_cnt_d;
            lfsr_q      <= lfsr_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            if (chal_load) begin
                chal_a_q <= chal_next[4:0];
                chal_b_q <= chal_next[9:5];
            end
        end
    end

    assign bus_if.chal_a    = chal_a_q;
    assign bus_if.chal_b    = chal_b_q;
    assign bus_if.osc_en    = (state_q == S_MEASURE);
    assign bus_if.cnt_clr   = (state_q == S_IDLE) || (state_q == S_CLEAR) || (state_q == S_DONE);
    assign bus_if.busy      = (state_q != S_IDLE);
    assign bus_if.key       = key_q;
    assign bus_if.key_valid = key_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_puf_challenge_issuer.sv
`default_nettype none
// tb_puf_challenge_issuer: randomized directed sequence against a per-measurement reference model.
module tb_puf_challenge_issuer;
    localparam int KW  = 4;
    localparam int WIN = 8;
    localparam int SET = 2;
    localparam int P   = WIN + SET + 2;
`ifdef PUF_MAJORITY_EN
    localparam int R = 3;
`else
    localparam int R = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    puf_challenge_issuer_if #(.KEY_W(KW)) u_if ();
    puf_challenge_issuer_if #(.KEY_W(16)) u_if16 ();

    puf_challenge_issuer #(.KEY_W(KW), .WINDOW(WIN), .SETTLE(SET)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus_if(u_if)
    );
    puf_challenge_issuer #(.KEY_W(16), .WINDOW(WIN), .SETTLE(SET)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus_if(u_if16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] lfsr_step(input logic [9:0] l);
        return {l[8:0], l[9] ^ l[6]};
    endfunction

    function automatic logic [4:0] exp_chal_b(input logic [9:0] l);
        return (l[9:5] == l[4:0]) ? (l[9:5] ^ 5'h01) : l[9:5];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 random responses, 1 all ones, 2 pattern 1,0,1,0,0,1 repeating per measurement
    task automatic run_key(input logic [7:0] seed, input int mode, input int hold,
                           input int abort_at, input bit mid_start, input bit start_with_ready);
        bit             rb [0:KW*R-1];
        logic [KW-1:0]  ek;
        logic [9:0]     l;
        int             nm, votes, k, o;
        nm = KW * R;
        for (int i = 0; i < nm; i++) begin
            case (mode)
                0:       rb[i] = 1'($urandom_range(0, 1));
                1:       rb[i] = 1'b1;
                default: rb[i] = ((i % 6) == 0) || ((i % 6) == 2) || ((i % 6) == 5);
            endcase
        end
        ek = '0;
        for (int b = 0; b < KW; b++) begin
            votes = 0;
            for (int r = 0; r < R; r++) votes += int'(rb[b*R + r]);
            ek = {ek[KW-2:0], (2 * votes > R)};
        end

        u_if.seed  = seed;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        l = {seed, 2'b01};
        for (int c = 0; c < nm * P; c++) begin
            k = c / P;
            o = c % P;
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_osc_en",    32'(u_if.osc_en),    32'd0);
                chk("rst_cnt_clr",   32'(u_if.cnt_clr),   32'd1);
                chk("rst_busy",      32'(u_if.busy),      32'd0);
                chk("rst_key_valid", 32'(u_if.key_valid), 32'd0);
                chk("rst_key",       32'(u_if.key),       32'd0);
                chk("rst_chal_a",    32'(u_if.chal_a),    32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                u_if.resp_bit = 1'b0;
                tick();
                return;
            end
            chk("busy",      32'(u_if.busy),      32'd1);
            chk("osc_en",    32'(u_if.osc_en),    32'(o >= 1 && o <= WIN));
            chk("cnt_clr",   32'(u_if.cnt_clr),   32'(o == 0));
            chk("chal_a",    32'(u_if.chal_a),    32'(l[4:0]));
            chk("chal_b",    32'(u_if.chal_b),    32'(exp_chal_b(l)));
            chk("key_valid", 32'(u_if.key_valid), 32'd0);
            u_if.resp_bit = rb[k];
            u_if.start    = mid_start && (c == P + 3);
            u_if.seed     = mid_start ? ~seed : seed;
            tick();
            if (o == P - 1 && (k % R) == R - 1 && (k / R) != KW - 1) l = lfsr_step(l);
        end
        u_if.start = 1'b0;
        chk("done_entry_valid", 32'(u_if.key_valid), 32'd0);
        chk("done_osc_en",      32'(u_if.osc_en),    32'd0);
        chk("done_cnt_clr",     32'(u_if.cnt_clr),   32'd1);
        tick();
        chk("latency_valid", 32'(u_if.key_valid), 32'd1);
        chk("key",           32'(u_if.key),       32'(ek));
        for (int h = 0; h < hold; h++) begin
            u_if.key_ready = 1'b0;
            tick();
            chk("hold_valid", 32'(u_if.key_valid), 32'd1);
            chk("hold_key",   32'(u_if.key),       32'(ek));
        end
        u_if.key_ready = 1'b1;
        u_if.start     = start_with_ready;
        tick();
        u_if.key_ready = 1'b0;
        u_if.start     = 1'b0;
        chk("hs_busy",  32'(u_if.busy),      32'd0);
        chk("hs_valid", 32'(u_if.key_valid), 32'd0);
        tick();
        chk("idle_busy",    32'(u_if.busy),    32'd0);
        chk("idle_cnt_clr", 32'(u_if.cnt_clr), 32'd1);
    endtask

    initial begin
        int n;
        u_if.start = 1'b0;   u_if.seed = 8'h00;   u_if.resp_bit = 1'b0;   u_if.key_ready = 1'b0;
        u_if16.start = 1'b0; u_if16.seed = 8'h00; u_if16.resp_bit = 1'b1; u_if16.key_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_chal_a",    32'(u_if.chal_a),    32'd0);
        chk("reset_chal_b",    32'(u_if.chal_b),    32'd0);
        chk("reset_osc_en",    32'(u_if.osc_en),    32'd0);
        chk("reset_cnt_clr",   32'(u_if.cnt_clr),   32'd1);
        chk("reset_busy",      32'(u_if.busy),      32'd0);
        chk("reset_key",       32'(u_if.key),       32'd0);
        chk("reset_key_valid", 32'(u_if.key_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Seed 0 must give first challenge a=1, b=0; responses all ones give 4'hF.
        u_if.seed = 8'h00;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        chk("seed0_chal_a", 32'(u_if.chal_a), 32'h01);
        chk("seed0_chal_b", 32'(u_if.chal_b), 32'h00);
        n = 0;
        while (!u_if.key_valid && n < KW * R * P + 10) begin
            u_if.resp_bit = 1'b1;
            tick();
            n++;
        end
        chk("tied1_latency", 32'(n),      32'(KW * R * P + 1));
        chk("tied1_key",     32'(u_if.key), 32'hF);
        u_if.key_ready = 1'b1;
        tick();
        u_if.key_ready = 1'b0;
        tick();

        run_key(8'h00, 1, 0, -1, 1'b0, 1'b0);
        run_key(8'($urandom), 2, 0, -1, 1'b0, 1'b0);
        run_key(8'($urandom), 0, 10, -1, 1'b1, 1'b0);
        run_key(8'($urandom), 0, 0, 2 * R * P + 4, 1'b0, 1'b0);
        run_key(8'($urandom), 0, 2, -1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) run_key(8'($urandom), 0, i, -1, 1'b0, 1'b0);

        u_if16.seed  = 8'($urandom);
        u_if16.start = 1'b1;
        tick();
        u_if16.start = 1'b0;
        n = 0;
        while (!u_if16.key_valid && n < 16 * R * P + 20) begin
            tick();
            n++;
        end
        chk("k16_latency", 32'(n),          32'(16 * R * P + 1));
        chk("k16_key",     32'(u_if16.key), 32'hFFFF);
        u_if16.key_ready = 1'b1;
        tick();
        u_if16.key_ready = 1'b0;
        chk("k16_busy", 32'(u_if16.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
